count_capture: RTL

Timestamp capture stage sitting directly downstream of the 32-bit free-running counter: it watches a synchronous event line and, on each rising edge, snapshots the counter's current `cnt` value into a small FIFO. Downstream logic drains the timestamps over a valid/ready handshake. Events arriving while the FIFO is full are dropped, counted and flagged, so bursts never stall the counter or the event source.

---
 rtl/count_capture.sv | 116 +++++++++++
 1 files changed

// File: rtl/count_capture.sv
// count_capture
//   Timestamp capture stage. On each rising edge of the synchronous event
//   line, the current 32-bit counter value is pushed into a small circular
//   FIFO. Downstream logic drains it over a valid/ready handshake. Events
//   arriving while the FIFO is full (and not popping) are dropped, counted
//   in a saturating counter, and flagged with a sticky overflow bit.
//
// Ports
//   clk        in   single rising-edge clock
//   rstn       in   synchronous active-low reset
//   cnt        in   32-bit counter value, sampled every cycle
//   evt        in   event line (synchronous to clk)
//   ovf_clr    in   pulse: clears overflow and drop_cnt
//   out_valid  out  FIFO head holds a timestamp
//   out_ready  in   consumer accepts head this cycle
//   out_data   out  timestamp at FIFO head (undefined when !out_valid)
//   level      out  number of stored entries, 0..2^LOG2_DEPTH
//   overflow   out  sticky drop flag
//   drop_cnt   out  dropped-capture count, saturating at 255
module count_capture #(
  parameter int LOG2_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [31:0]           cnt,
  input  logic                  evt,
  input  logic                  ovf_clr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_data,
  output logic [LOG2_DEPTH:0]   level,
  output logic                  overflow,
  output logic [7:0]            drop_cnt
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0] L_FULL = {1'b1, {LOG2_DEPTH{1'b0}}};

  logic [31:0]           r_mem [0:DEPTH-1];
  logic [LOG2_DEPTH-1:0] r_wr_ptr;
  logic [LOG2_DEPTH-1:0] r_rd_ptr;
  logic [LOG2_DEPTH:0]   r_level;
  logic                  r_evt_d;
  logic                  r_overflow;
  logic [7:0]            r_drop_cnt;

  logic w_req;
  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_drop;

  always_comb begin
    w_req   = evt & ~r_evt_d;
    w_full  = (r_level == L_FULL);
    w_empty = (r_level == '0);
    w_pop   = ~w_empty & out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    w_push  = w_req & (~w_full | w_pop);
    w_drop  = w_req & w_full & ~w_pop;
  end

  // Storage carries no reset; stale contents are unreachable once level is 0.
  always_ff @(posedge clk) begin
    if (rstn && w_push) begin
      r_mem[r_wr_ptr] <= cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_evt_d    <= 1'b1;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_evt_d <= evt;

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end

      if (w_push && !w_pop) begin
        r_level <= r_level + 1'b1;
      end else if (w_pop && !w_push) begin
        r_level <= r_level - 1'b1;
      end

      // A drop in the same cycle as a clear wins, restarting the count at 1.
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (ovf_clr) begin
          r_drop_cnt <= 8'd1;
        end else if (r_drop_cnt != 8'hFF) begin
          r_drop_cnt <= r_drop_cnt + 8'd1;
        end
      end else if (ovf_clr) begin
        r_overflow <= 1'b0;
        r_drop_cnt <= '0;
      end
    end
  end

  assign out_valid = ~w_empty;
  assign out_data  = r_mem[r_rd_ptr];
  assign level     = r_level;
  assign overflow  = r_overflow;
  assign drop_cnt  = r_drop_cnt;

endmodule
